// File: rtl/microsequencer_p_if.sv
// Bus bundle between the microprogram sequencer and its datapath / control store.
// master = sequencer side, slave = environment (control store, decoder, flags).
interface microsequencer_p_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CTL_W  = 64,
  parameter int unsigned SEL_W  = 3
);
  localparam int unsigned COND_N = 1 << SEL_W;

  logic              MOC;
  logic [COND_N-1:0] COND_IN;
  logic [ADDR_W-1:0] DEC_ADDR;
  logic [CTL_W-1:0]  UDATA;
  logic [ADDR_W-1:0] UADDR;
  logic [CTL_W-1:0]  CTL;
  logic [ADDR_W-1:0] CUR_ADDR;
  logic              STALL;
  logic              STK_ERR;

  modport master (
    input  MOC, COND_IN, DEC_ADDR, UDATA,
    output UADDR, CTL, CUR_ADDR, STALL, STK_ERR
  );

  modport slave (
    output MOC, COND_IN, DEC_ADDR, UDATA,
    input  UADDR, CTL, CUR_ADDR, STALL, STK_ERR
  );
endinterface

// File: rtl/microsequencer_p.sv
// Parametrised microprogram sequencer: microinstruction register, next-address logic,
// memory-wait stall and WAIT op. Optional return stack enabled by defining USEQ_STACK_EN.
module microsequencer_p #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned CTL_W       = 64,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned FETCH_ADDR  = 0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic CLK,
  input logic RST_N,
  microsequencer_p_if.master bus
);

  localparam int unsigned N_HI   = CTL_W - 7;
  localparam int unsigned INV_B  = CTL_W - 10;
  localparam int unsigned MI_B   = CTL_W - 11;
  localparam int unsigned SEL_HI = CTL_W - 12;
  localparam int unsigned CR_HI  = CTL_W - 12 - SEL_W;

  typedef enum logic [2:0] {
    OP_FETCH  = 3'd0,
    OP_CONT   = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CJUMP  = 3'd3,
    OP_DECODE = 3'd4,
    OP_WAIT   = 3'd5,
    OP_CALL   = 3'd6,
    OP_RET    = 3'd7
  } op_e;

  logic [CTL_W-1:0]  ctl_q, ctl_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

  op_e               op;
  logic              inv, mi, cond;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] cr, inc, fetch_a, uaddr;
  logic              stall, push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty;

  always_comb begin
    op      = op_e'(ctl_q[N_HI -: 3]);
    inv     = ctl_q[INV_B];
    mi      = ctl_q[MI_B];
    sel     = ctl_q[SEL_HI -: SEL_W];
    cr      = ctl_q[CR_HI -: ADDR_W];
    cond    = bus.COND_IN[sel] ^ inv;
    inc     = cur_addr_q + ADDR_W'(1);
    fetch_a = ADDR_W'(FETCH_ADDR);
  end

  // Memory-wait stall has priority over every op and suppresses stack activity.
  always_comb begin
    uaddr = cur_addr_q;
    stall = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (mi && !bus.MOC) begin
      stall = 1'b1;
    end else begin
      case (op)
        OP_FETCH:  uaddr = fetch_a;
        OP_CONT:   uaddr = inc;
        OP_JUMP:   uaddr = cr;
        OP_CJUMP:  uaddr = cond ? cr : inc;
        OP_DECODE: uaddr = bus.DEC_ADDR;
        OP_WAIT: begin
          if (cond) uaddr = inc;
          else      stall = 1'b1;
        end
        OP_CALL: begin
          uaddr = cr;
          push  = 1'b1;
        end
        OP_RET: begin
          uaddr = stk_empty ? fetch_a : stk_top;
          pop   = 1'b1;
        end
        default: uaddr = fetch_a;
      endcase
    end
  end

  always_comb begin
    ctl_d      = bus.UDATA;
    cur_addr_d = uaddr;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctl_q      <= '0;
      cur_addr_q <= ADDR_W'(FETCH_ADDR);
    end else begin
      ctl_q      <= ctl_d;
      cur_addr_q <= cur_addr_d;
    end
  end

`ifdef USEQ_STACK_EN
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stk_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stk_err_q, stk_err_d;

  // Entry sp-1 is the top of stack; selected by compare to avoid out-of-range indexing.
  always_comb begin
    stk_empty = (sp_q == '0);
    stk_top   = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i + 1) == sp_q) stk_top = stk_q[i];
    end
  end

  always_comb begin
    stk_d     = stk_q;
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
    if (push) begin
      if (sp_q == SP_W'(STACK_DEPTH)) begin
        stk_err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
          if (SP_W'(i) == sp_q) stk_d[i] = inc;
        end
        sp_d = sp_q + SP_W'(1);
      end
    end else if (pop) begin
      if (stk_empty) stk_err_d = 1'b1;
      else           sp_d      = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      sp_q      <= '0;
      stk_err_q <= 1'b0;
    end else begin
      stk_q     <= stk_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign bus.STK_ERR = stk_err_q;
`else
  // Without a stack, CALL behaves as JUMP and RET as FETCH.
  logic unused_stk;
  assign stk_empty   = 1'b1;
  assign stk_top     = '0;
  assign unused_stk  = push ^ pop ^ (STACK_DEPTH == 0);
  assign bus.STK_ERR = 1'b0;
`endif

  assign bus.UADDR    = uaddr;
  assign bus.CTL      = ctl_q;
  assign bus.CUR_ADDR = cur_addr_q;
  assign bus.STALL    = stall;

endmodule

// File: tb/tb_microsequencer_p.sv
// Scoreboard bench for microsequencer_p: directed microprograms in a modelled control store.
// Stack checks follow USEQ_STACK_EN, matching the RTL build.
module tb_microsequencer_p;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CTL_W  = 64;
  localparam int unsigned SEL_W  = 3;

  localparam logic [2:0] FETCH = 3'd0, CONT = 3'd1, JUMP = 3'd2, CJUMP = 3'd3,
                         DECODE = 3'd4, WAITOP = 3'd5, CALL = 3'd6, RET = 3'd7;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [CTL_W-1:0]  ctl;
    logic              stall;
    logic              err;
  } exp_t;

  logic clk;
  logic rst_n;
  bit [CTL_W-1:0] rom [0:65535];
  exp_t sbq [$];
  int vecs;
  int errs;

  microsequencer_p_if #(.ADDR_W(ADDR_W), .CTL_W(CTL_W), .SEL_W(SEL_W)) bus ();

  microsequencer_p #(
    .ADDR_W(ADDR_W), .CTL_W(CTL_W), .SEL_W(SEL_W), .FETCH_ADDR(0), .STACK_DEPTH(4)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  assign bus.UDATA = rom[bus.UADDR];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [CTL_W-1:0] mk(input logic [2:0] n, input bit inv, input bit mi,
                                        input logic [2:0] sel, input logic [15:0] cr,
                                        input logic [15:0] tag);
    bit [CTL_W-1:0] w;
    w        = '0;
    w[57:55] = n;
    w[54]    = inv;
    w[53]    = mi;
    w[52:50] = sel;
    w[49:34] = cr;
    w[15:0]  = tag;
    return w;
  endfunction

  task automatic put(input logic [15:0] a, input logic [2:0] n, input bit inv, input bit mi,
                     input logic [2:0] sel, input logic [15:0] cr);
    rom[a] = mk(n, inv, mi, sel, cr, a ^ 16'hA5A5);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: queue what the DUT must show after the edge, then return at the falling edge.
  task automatic step(input logic [15:0] a, input bit st, input bit er);
    exp_t e;
    e.addr  = a;
    e.ctl   = rom[a];
    e.stall = st;
    e.err   = er;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("cur_addr", 64'(bus.CUR_ADDR), 64'(e.addr));
      chk("ctl",      64'(bus.CTL),      64'(e.ctl));
      chk("stall",    64'(bus.STALL),    64'(e.stall));
      chk("stk_err",  64'(bus.STK_ERR),  64'(e.err));
    end
  end

  initial begin
    vecs = 0;
    errs = 0;
    rst_n        = 1'b0;
    bus.MOC      = 1'b1;
    bus.COND_IN  = 8'h04;
    bus.DEC_ADDR = 16'h0000;
    put(16'h0000, CJUMP, 0, 0, 3'd2, 16'h0020);
    put(16'h0020, FETCH, 0, 0, 3'd0, 16'h0000);
    put(16'h0001, FETCH, 0, 0, 3'd0, 16'h0000);

    #2;
    chk("rst_ctl",   64'(bus.CTL),      64'h0);
    chk("rst_cur",   64'(bus.CUR_ADDR), 64'h0);
    chk("rst_uaddr", 64'(bus.UADDR),    64'h0);
    chk("rst_stall", 64'(bus.STALL),    64'h0);
    chk("rst_err",   64'(bus.STK_ERR),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // CJUMP taken / not taken, then with INV
    step(16'h0000, 0, 0);
    step(16'h0020, 0, 0);
    step(16'h0000, 0, 0);
    bus.COND_IN[2] = 1'b0;
    step(16'h0001, 0, 0);
    put(16'h0000, CJUMP, 1, 0, 3'd2, 16'h0020);
    step(16'h0000, 0, 0);
    step(16'h0020, 0, 0);
    step(16'h0000, 0, 0);
    bus.COND_IN[2] = 1'b1;
    step(16'h0001, 0, 0);

    // Memory-wait stall for three extra cycles
    put(16'h0000, CONT, 0, 1, 3'd0, 16'h0000);
    bus.MOC = 1'b0;
    step(16'h0000, 1, 0);
    step(16'h0000, 1, 0);
    step(16'h0000, 1, 0);
    step(16'h0000, 1, 0);
    bus.MOC = 1'b1;
    #1;
    chk("stall_release", 64'(bus.STALL), 64'h0);
    chk("uaddr_release", 64'(bus.UADDR), 64'h1);
    step(16'h0001, 0, 0);

    // WAIT op holds until its condition rises
    put(16'h0000, WAITOP, 0, 0, 3'd1, 16'h0000);
    bus.COND_IN[1] = 1'b0;
    step(16'h0000, 1, 0);
    step(16'h0000, 1, 0);
    bus.COND_IN[1] = 1'b1;
    step(16'h0001, 0, 0);

    // DECODE, then CONT wrapping from all-ones to zero
    put(16'h0000, DECODE, 0, 0, 3'd0, 16'h0000);
    put(16'h0010, JUMP,   0, 0, 3'd0, 16'hFFFF);
    put(16'hFFFF, CONT,   0, 0, 3'd0, 16'h0000);
    bus.DEC_ADDR = 16'h0010;
    step(16'h0000, 0, 0);
    step(16'h0010, 0, 0);
    step(16'hFFFF, 0, 0);
    step(16'h0000, 0, 0);

    // CALL / RET
    put(16'h0005, CALL,  0, 0, 3'd0, 16'h0040);
    put(16'h0040, RET,   0, 0, 3'd0, 16'h0000);
    put(16'h0006, FETCH, 0, 0, 3'd0, 16'h0000);
    bus.DEC_ADDR = 16'h0005;
    step(16'h0005, 0, 0);
    step(16'h0040, 0, 0);
`ifdef USEQ_STACK_EN
    step(16'h0006, 0, 0);
    step(16'h0000, 0, 0);
    for (int unsigned i = 0; i < 5; i++) put(16'(16'h0050 + i), CALL, 0, 0, 3'd0, 16'(16'h0051 + i));
    put(16'h0055, FETCH, 0, 0, 3'd0, 16'h0000);
    bus.DEC_ADDR = 16'h0050;
    step(16'h0050, 0, 0);
    step(16'h0051, 0, 0);
    step(16'h0052, 0, 0);
    step(16'h0053, 0, 0);
    step(16'h0054, 0, 0);
    step(16'h0055, 0, 1);
    step(16'h0000, 0, 1);
`else
    step(16'h0000, 0, 0);
`endif

    // Asynchronous reset between clock edges
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl",   64'(bus.CTL),      64'h0);
    chk("mid_rst_cur",   64'(bus.CUR_ADDR), 64'h0);
    chk("mid_rst_uaddr", 64'(bus.UADDR),    64'h0);
    chk("mid_rst_err",   64'(bus.STK_ERR),  64'h0);
    #1;
    rst_n = 1'b1;
    put(16'h0000, RET, 0, 0, 3'd0, 16'h0000);
    step(16'h0000, 0, 0);
`ifdef USEQ_STACK_EN
    step(16'h0000, 0, 1);
`else
    step(16'h0000, 0, 0);
`endif

    @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
